mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Responder end of the CPU byte-serial memory protocol: arbitrates IF and MEM stage byte requests onto one
//  synchronous single-port byte RAM. Forwards granted address/write strobe/data; returns read byte one cycle
//  later. Sits between the CPU pipeline (IF, MEM requesters) and the RAM/IO fabric at the top level.
// PARAMETERS
//  RAM_AW    17           RAM byte-address width; ram_addr_o = granted addr[RAM_AW-1:0]
//  IO_BASE   32'h0003_0000 first IO byte address (used only with MEM_CTRL_IO_EN)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   asynchronous, active-low reset (0 = reset)
//  if_req_i     in   1   IF requests a read byte this cycle
//  if_addr_i    in   32  IF byte address
//  mem_req_i    in   1   MEM requests a byte access this cycle
//  mem_addr_i   in   32  MEM byte address
//  mem_we_i     in   1   MEM access is a write
//  mem_wdata_i  in   8   MEM write byte
//  if_gnt_o     out  1   IF address forwarded this cycle (comb)
//  mem_gnt_o    out  1   MEM address forwarded this cycle (comb)
//  if_stall_o   out  1   if_req_i & !if_gnt_o (comb)
//  rdata_o      out  8   read byte, valid when *_valid_o
//  if_valid_o   out  1   rdata_o belongs to IF read granted previous cycle
//  mem_valid_o  out  1   rdata_o belongs to MEM read granted previous cycle
//  ram_addr_o   out  RAM_AW  RAM byte address (comb from granted port)
//  ram_we_o     out  1   RAM write strobe (comb)
//  ram_wdata_o  out  8   RAM write byte (comb)
//  ram_rdata_i  in   8   RAM read byte for address of previous cycle
// BEHAVIOUR
//  - Owner FSM (registered): IDLE, OWN_IF, OWN_MEM. Reset -> IDLE.
//  - Grant (comb): OWN_IF & if_req_i -> IF; OWN_MEM & mem_req_i -> MEM; else mem_req_i -> MEM; else if_req_i -> IF.
//    MEM has priority only when the bus is not locked; lock holds while owner keeps req high (no IF word torn).
//  - Next owner = granted port; no grant -> IDLE. Owner dropping req frees bus same cycle (other port may win).
//  - Ungranted: ram_we_o=0, ram_addr_o=0, ram_wdata_o=0. RAM write only for MEM grant with mem_we_i=1.
//  - Read latency 1: valid flag registered = grant & !we; rdata_o = ram_rdata_i passthrough (comb);
//    exactly one of if_valid_o/mem_valid_o in a cycle. Write grants produce no valid.
//  - Back-to-back: one byte per cycle per granted port; 4-byte word = 4 grant cycles, 4 valids, offset 1.
//  - Addresses above RAM_AW truncated; no wrap check.
//  - Reset (any time, incl. mid-word): owner=IDLE, valids=0, grants/ram_we_o forced 0 while rst=0; the
//    in-flight access is dropped, no partial write after release.
//  - Reset values: all outputs 0.
// CONFIGURATION
//  MEM_CTRL_IO_EN defined: MEM accesses with addr >= IO_BASE bypass RAM: ram_we_o=0, write raises io_we_o
//    with io_wdata_o (extra ports io_we_o 1, io_wdata_o 8, io_rdata_i 8); read returns io_rdata_i sampled
//    at grant, registered, with the same 1-cycle latency; IF never targets IO.
//  Not defined: no IO ports; all addresses go to RAM.
// STRUCTURE
//  Shared package/defines: owner state encodings (OWN_IDLE/OWN_IF/OWN_MEM), ZeroWord, True/False,
//  byte-width constant. No sub-module; FSM, grant mux and valid pipeline are inline.
// TESTING
//  1 IF-only read 0x100..0x103 (RAM AA,BB,CC,DD) -> if_gnt each cycle; if_valid cycles 2-5 rdata AA,BB,CC,DD.
//  2 MEM write 0x200=5A, mem_we=1 single cycle -> ram_we=1, ram_addr=0x200, ram_wdata=5A; no mem_valid next.
//  3 IF owns bus mid-word, mem_req rises -> if_gnt held until if_req drops; mem_gnt same cycle after; if_stall=0 throughout.
//  4 Both req from IDLE -> mem_gnt=1, if_stall=1 until mem_req drops; then if granted same cycle.
//  5 rst low during 2nd byte of MEM read -> all outputs 0 immediately; after release no mem_valid, owner IDLE.
//  6 (IO_EN) MEM write 0x30000=41 -> io_we=1, io_wdata=41, ram_we=0; read 0x30004 -> mem_valid next cycle, rdata=io_rdata.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for mem_ctrl: owner state encodings, byte width and fill words.
package mem_ctrl_pkg;

  localparam int unsigned ByteW    = 8;
  localparam logic        True     = 1'b1;
  localparam logic        False    = 1'b0;
  localparam logic [31:0] ZeroWord = '0;

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory responder: arbitrates IF/MEM byte requests onto one synchronous byte RAM.
// Optional IO window above IO_BASE is enabled by defining MEM_CTRL_IO_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_AW  = 17,
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              mem_req_i,
  input  logic [31:0]       mem_addr_i,
  input  logic              mem_we_i,
  input  logic [ByteW-1:0]  mem_wdata_i,
  output logic              if_gnt_o,
  output logic              mem_gnt_o,
  output logic              if_stall_o,
  output logic [ByteW-1:0]  rdata_o,
  output logic              if_valid_o,
  output logic              mem_valid_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [ByteW-1:0]  ram_wdata_o,
`ifdef MEM_CTRL_IO_EN
  output logic              io_we_o,
  output logic [ByteW-1:0]  io_wdata_o,
  input  logic [ByteW-1:0]  io_rdata_i,
`endif
  input  logic [ByteW-1:0]  ram_rdata_i
);

  logic [1:0] own_q, own_d;
  logic       if_valid_q, mem_valid_q;
  logic       if_gnt, mem_gnt, io_sel;
  logic       io_rd_q;
  logic [ByteW-1:0] io_rdata_q;

  // Current owner keeps the bus while it holds req; otherwise MEM beats IF.
  always_comb begin
    if_gnt  = False;
    mem_gnt = False;
    if (rst) begin
      if (own_q == OWN_IF && if_req_i)        if_gnt  = True;
      else if (own_q == OWN_MEM && mem_req_i) mem_gnt = True;
      else if (mem_req_i)                     mem_gnt = True;
      else if (if_req_i)                      if_gnt  = True;
    end
    own_d = mem_gnt ? OWN_MEM : (if_gnt ? OWN_IF : OWN_IDLE);
  end

`ifdef MEM_CTRL_IO_EN
  assign io_sel     = mem_gnt && (mem_addr_i >= IO_BASE);
  assign io_we_o    = io_sel && mem_we_i;
  assign io_wdata_o = io_we_o ? mem_wdata_i : '0;
`else
  assign io_sel     = False;
`endif

  always_comb begin
    ram_addr_o  = ZeroWord[RAM_AW-1:0];
    ram_we_o    = False;
    ram_wdata_o = '0;
    if (if_gnt) begin
      ram_addr_o = if_addr_i[RAM_AW-1:0];
    end else if (mem_gnt) begin
      ram_addr_o = mem_addr_i[RAM_AW-1:0];
      if (!io_sel) begin
        ram_we_o    = mem_we_i;
        ram_wdata_o = mem_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_q       <= OWN_IDLE;
      if_valid_q  <= False;
      mem_valid_q <= False;
      io_rd_q     <= False;
      io_rdata_q  <= '0;
    end else begin
      own_q       <= own_d;
      if_valid_q  <= if_gnt;
      mem_valid_q <= mem_gnt && !mem_we_i;
      io_rd_q     <= io_sel && !mem_we_i;
`ifdef MEM_CTRL_IO_EN
      if (io_sel && !mem_we_i) io_rdata_q <= io_rdata_i;
`endif
    end
  end

  // rdata is a passthrough, but held at 0 while reset is asserted.
  assign rdata_o     = !rst ? '0 : (io_rd_q ? io_rdata_q : ram_rdata_i);
  assign if_valid_o  = if_valid_q;
  assign mem_valid_o = mem_valid_q;
  assign if_gnt_o    = if_gnt;
  assign mem_gnt_o   = mem_gnt;
  assign if_stall_o  = if_req_i && !if_gnt;

  logic unused_bits;
  assign unused_bits = ^{if_addr_i[31:RAM_AW], mem_addr_i[31:RAM_AW], IO_BASE};

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, reset corner case, randomized traffic vs. a reference model.
module tb_mem_ctrl;

  localparam int AW = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr;
  logic [7:0]  mem_wdata;
  logic        if_gnt, mem_gnt, if_stall, if_valid, mem_valid, ram_we;
  logic [7:0]  rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
`ifdef MEM_CTRL_IO_EN
  logic        io_we;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata = 8'h99;
`endif

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .mem_req_i(mem_req), .mem_addr_i(mem_addr), .mem_we_i(mem_we), .mem_wdata_i(mem_wdata),
    .if_gnt_o(if_gnt), .mem_gnt_o(mem_gnt), .if_stall_o(if_stall),
    .rdata_o(rdata), .if_valid_o(if_valid), .mem_valid_o(mem_valid),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
`ifdef MEM_CTRL_IO_EN
    .io_we_o(io_we), .io_wdata_o(io_wdata), .io_rdata_i(io_rdata),
`endif
    .ram_rdata_i(ram_rdata)
  );

  // Environment RAM: synchronous single port, content defaults to a hash of the address.
  logic [7:0] ram_env [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] dflt(int a);
    return 8'(a ^ (a >> 8) ^ 8'h3C);
  endfunction

  always @(posedge clk) begin
    if (ram_we) ram_env[int'(ram_addr)] = ram_wdata;
    ram_rdata <= ram_env.exists(int'(ram_addr)) ? ram_env[int'(ram_addr)] : dflt(int'(ram_addr));
  end

  function automatic logic [7:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (0 none, 1 IF, 2 MEM) and what read is in flight.
  int m_own   = 0;
  int m_prev  = 0;
  int m_paddr = 0;

  typedef struct {
    logic        ifr;  logic [31:0] ia;
    logic        mr;   logic [31:0] ma; logic we; logic [7:0] wd;
    logic        ig, mg, st, iv, mv; logic [7:0] rd;
    logic        rwe;  logic [31:0] ra; logic [7:0] rwd;
  } vec_t;

  function automatic vec_t V(logic ifr, logic [31:0] ia, logic mr, logic [31:0] ma, logic we, logic [7:0] wd,
                             logic ig, logic mg, logic st, logic iv, logic mv, logic [7:0] rd,
                             logic rwe, logic [31:0] ra, logic [7:0] rwd);
    vec_t v;
    v.ifr = ifr; v.ia = ia; v.mr = mr; v.ma = ma; v.we = we; v.wd = wd;
    v.ig = ig; v.mg = mg; v.st = st; v.iv = iv; v.mv = mv; v.rd = rd;
    v.rwe = rwe; v.ra = ra; v.rwd = rwd;
    return v;
  endfunction

  // Drive one cycle, compare at the falling edge against the table row or the model, then advance the model.
  task automatic step(input vec_t v, input bit use_tbl);
    int g;
    vec_t e;
    if_req = v.ifr; if_addr = v.ia; mem_req = v.mr; mem_addr = v.ma; mem_we = v.we; mem_wdata = v.wd;
    @(negedge clk);
    if (m_own == 1 && v.ifr)      g = 1;
    else if (m_own == 2 && v.mr)  g = 2;
    else if (v.mr)                g = 2;
    else if (v.ifr)               g = 1;
    else                          g = 0;
    if (use_tbl) e = v;
    else begin
      e = v;
      e.ig = (g == 1); e.mg = (g == 2); e.st = v.ifr && (g != 1);
      e.iv = (m_prev == 1); e.mv = (m_prev == 2); e.rd = ref_rd(m_paddr);
      e.rwe = (g == 2) && v.we;
      e.ra  = (g == 1) ? (v.ia % (1 << AW)) : (g == 2) ? (v.ma % (1 << AW)) : 0;
      e.rwd = (g == 2) ? v.wd : 8'h00;
    end
    chk("if_gnt", 32'(if_gnt), 32'(e.ig));
    chk("mem_gnt", 32'(mem_gnt), 32'(e.mg));
    chk("if_stall", 32'(if_stall), 32'(e.st));
    chk("if_valid", 32'(if_valid), 32'(e.iv));
    chk("mem_valid", 32'(mem_valid), 32'(e.mv));
    if (e.iv || e.mv) chk("rdata", 32'(rdata), 32'(e.rd));
    chk("ram_we", 32'(ram_we), 32'(e.rwe));
    chk("ram_addr", 32'(ram_addr), e.ra);
    chk("ram_wdata", 32'(ram_wdata), 32'(e.rwd));
    if (g == 2 && v.we) ref_mem[int'(v.ma % (1 << AW))] = v.wd;
    m_prev  = (g == 1) ? 1 : (g == 2 && !v.we) ? 2 : 0;
    m_paddr = (g == 1) ? int'(v.ia % (1 << AW)) : int'(v.ma % (1 << AW));
    m_own   = g;
    @(posedge clk); #1;
  endtask

  task automatic preload(int a, logic [7:0] d);
    ram_env[a] = d;
    ref_mem[a] = d;
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    rst = 1'b0; if_req = 0; mem_req = 0; mem_we = 0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
    idle = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    preload('h100, 8'hAA); preload('h101, 8'hBB); preload('h102, 8'hCC); preload('h103, 8'hDD);
    preload('h300, 8'h11); preload('h301, 8'h22); preload('h302, 8'h33); preload('h303, 8'h44);
    preload('h400, 8'h77); preload('h500, 8'h55); preload('h600, 8'h66); preload('h601, 8'h67);

    // IF burst read
    tbl.push_back(V(1, 'h100, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0,     0, 'h100, 0));
    tbl.push_back(V(1, 'h101, 0, 0, 0, 0,  1, 0, 0, 1, 0, 'hAA,  0, 'h101, 0));
    tbl.push_back(V(1, 'h102, 0, 0, 0, 0,  1, 0, 0, 1, 0, 'hBB,  0, 'h102, 0));
    tbl.push_back(V(1, 'h103, 0, 0, 0, 0,  1, 0, 0, 1, 0, 'hCC,  0, 'h103, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 'hDD,  0, 0, 0));
    // MEM write, no valid afterwards
    tbl.push_back(V(0, 0, 1, 'h200, 1, 'h5A, 0, 1, 0, 0, 0, 0,   1, 'h200, 'h5A));
    tbl.push_back(idle);
    // IF holds the lock while MEM waits
    tbl.push_back(V(1, 'h300, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0,    0, 'h300, 0));
    tbl.push_back(V(1, 'h301, 1, 'h400, 0, 0,  1, 0, 0, 1, 0, 'h11, 0, 'h301, 0));
    tbl.push_back(V(1, 'h302, 1, 'h400, 0, 0,  1, 0, 0, 1, 0, 'h22, 0, 'h302, 0));
    tbl.push_back(V(1, 'h303, 1, 'h400, 0, 0,  1, 0, 0, 1, 0, 'h33, 0, 'h303, 0));
    tbl.push_back(V(0, 0, 1, 'h400, 0, 0,      0, 1, 0, 1, 0, 'h44, 0, 'h400, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 'h77, 0, 0, 0));
    // Both request from IDLE: MEM wins, IF stalls
    tbl.push_back(V(1, 'h500, 1, 'h600, 0, 0,  0, 1, 1, 0, 0, 0,    0, 'h600, 0));
    tbl.push_back(V(1, 'h500, 1, 'h601, 0, 0,  0, 1, 1, 0, 1, 'h66, 0, 'h601, 0));
    tbl.push_back(V(1, 'h500, 0, 0, 0, 0,      1, 0, 0, 0, 1, 'h67, 0, 'h500, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0,          0, 0, 0, 1, 0, 'h55, 0, 0, 0));
    // Read-back of the write and address truncation on both ports
    tbl.push_back(V(0, 0, 1, 'h200, 0, 'hC3,   0, 1, 0, 0, 0, 0,    0, 'h200, 'hC3));
    tbl.push_back(V(0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 'h5A, 0, 0, 0));
    tbl.push_back(V(1, 'hFFFE_0100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 'h100, 0));
    tbl.push_back(V(0, 0, 1, 'h0002_0200, 0, 0, 0, 1, 0, 1, 0, 'hAA, 0, 'h200, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 'h5A, 0, 0, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst if_gnt", 32'(if_gnt), 0);   chk("rst mem_gnt", 32'(mem_gnt), 0);
    chk("rst if_valid", 32'(if_valid), 0); chk("rst mem_valid", 32'(mem_valid), 0);
    chk("rst rdata", 32'(rdata), 0);     chk("rst ram_we", 32'(ram_we), 0);
    chk("rst ram_addr", 32'(ram_addr), 0); chk("rst ram_wdata", 32'(ram_wdata), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

    // Reset asserted during the second byte of a MEM read
    step(V(0, 0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    mem_req = 1; mem_addr = 'h101; mem_we = 0;
    #2 rst = 1'b0;
    #1;
    chk("midrst mem_gnt", 32'(mem_gnt), 0); chk("midrst if_gnt", 32'(if_gnt), 0);
    chk("midrst mem_valid", 32'(mem_valid), 0); chk("midrst if_valid", 32'(if_valid), 0);
    chk("midrst rdata", 32'(rdata), 0);     chk("midrst ram_we", 32'(ram_we), 0);
    chk("midrst ram_addr", 32'(ram_addr), 0); chk("midrst if_stall", 32'(if_stall), 0);
    mem_req = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_own = 0; m_prev = 0;
    step(idle, 1'b0);
    step(V(1, 'h104, 1, 'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Randomized traffic: bursty requests, small MEM window so reads hit earlier writes
    for (int i = 0; i < 400; i++) begin
      vec_t r;
      r = idle;
      r.ifr = ($urandom_range(0, 3) != 0);
      r.ia  = ($urandom() & 32'hFFFC_0000) | 32'($urandom_range(0, 63));
      r.mr  = ($urandom_range(0, 2) == 0);
      r.ma  = 32'($urandom_range(0, 63));
      r.we  = $urandom_range(0, 1) != 0;
      r.wd  = 8'($urandom());
      step(r, 1'b0);
    end
    step(idle, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
